// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: EX/MEM pipeline register, SRAM read-data hold, load extract.
// Optional misaligned-load detection is enabled by defining MEM_ADDR_ERR_CHECK_EN.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int LOAD_WD      = 5,
  parameter int HILO_WD      = 66
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_WD-1:0]      ex_load_bus,
  input  logic [HILO_WD-1:0]      ex_hi_lo_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic [HILO_WD-1:0]      mem_hi_lo_bus,
  output logic                    mem_addr_err
);

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_q, ex_to_mem_d;
  logic [LOAD_WD-1:0]      load_q, load_d;
  logic [HILO_WD-1:0]      hi_lo_q, hi_lo_d;
  logic                    fresh_q, fresh_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [31:0]             hold_data_q, hold_data_d;

  logic        stage_load;
  logic        stage_bubble;

  assign stage_load   = ~stall[3];
  assign stage_bubble = stall[3] & ~stall[4];

  always_comb begin
    ex_to_mem_d = ex_to_mem_q;
    load_d      = load_q;
    hi_lo_d     = hi_lo_q;
    fresh_d     = 1'b0;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (stage_bubble) begin
      ex_to_mem_d = '0;
      load_d      = '0;
      hi_lo_d     = '0;
      hold_vld_d  = 1'b0;
    end else if (stage_load) begin
      ex_to_mem_d = ex_to_mem_bus;
      load_d      = ex_load_bus;
      hi_lo_d     = ex_hi_lo_bus;
      fresh_d     = 1'b1;
      hold_vld_d  = 1'b0;
    end else if (fresh_q && stall[4]) begin
      // SRAM data is only valid in the first MEM cycle; keep it for the rest of the stall
      hold_data_d = data_sram_rdata;
      hold_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_q <= '0;
      load_q      <= '0;
      hi_lo_q     <= '0;
      fresh_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      ex_to_mem_q <= ex_to_mem_d;
      load_q      <= load_d;
      hi_lo_q     <= hi_lo_d;
      fresh_q     <= fresh_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  logic [31:0] pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] result;
  logic [1:0]  addr;

  assign pc         = ex_to_mem_q[75:44];
  assign sel_rf_res = ex_to_mem_q[38];
  assign rf_we      = ex_to_mem_q[37];
  assign rf_waddr   = ex_to_mem_q[36:32];
  assign result     = ex_to_mem_q[31:0];
  assign addr       = result[1:0];

  logic inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw;
  assign {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw} = load_q;

  logic [31:0] rdata_eff;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign rdata_eff = hold_vld_q ? hold_data_q : data_sram_rdata;

  always_comb begin
    byte_sel = rdata_eff[7:0];
    case (addr)
      2'd0: byte_sel = rdata_eff[7:0];
      2'd1: byte_sel = rdata_eff[15:8];
      2'd2: byte_sel = rdata_eff[23:16];
      2'd3: byte_sel = rdata_eff[31:24];
      default: byte_sel = rdata_eff[7:0];
    endcase
  end

  assign half_sel = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_data = rdata_eff;
    if (inst_lb) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (inst_lbu) begin
      load_data = {24'h0, byte_sel};
    end else if (inst_lh) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (inst_lhu) begin
      load_data = {16'h0, half_sel};
    end else if (inst_lw) begin
      load_data = rdata_eff;
    end
  end

  logic addr_err;

`ifdef MEM_ADDR_ERR_CHECK_EN
  assign addr_err = ((inst_lh | inst_lhu) & addr[0]) | (inst_lw & (addr != 2'b00));
`else
  assign addr_err = 1'b0;
`endif

  logic        rf_we_out;
  logic [31:0] rf_wdata;

  assign rf_we_out = rf_we & ~addr_err;
  assign rf_wdata  = sel_rf_res ? load_data : result;

  assign mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = mem_to_wb_bus[37:0];
  assign mem_hi_lo_bus = hi_lo_q;
  assign mem_addr_err  = addr_err;

  // memory request fields and unrelated stall bits are consumed elsewhere in the core
  logic unused_bits;
  assign unused_bits = &{stall[5], stall[2:0], ex_to_mem_q[43:39]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected stage outputs are queued when an instruction is driven
// and popped when it reaches MEM; covers load extract, stall hold, bubble, HI/LO and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [65:0] ex_hi_lo_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic [65:0] mem_hi_lo_bus;
  logic        mem_addr_err;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_load_bus     (ex_load_bus),
    .ex_hi_lo_bus    (ex_hi_lo_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .mem_hi_lo_bus   (mem_hi_lo_bus),
    .mem_addr_err    (mem_addr_err)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] LD_NONE = 5'b00000;
  localparam logic [4:0] LD_LB   = 5'b10000;
  localparam logic [4:0] LD_LBU  = 5'b01000;
  localparam logic [4:0] LD_LH   = 5'b00100;
  localparam logic [4:0] LD_LHU  = 5'b00010;
  localparam logic [4:0] LD_LW   = 5'b00001;

  localparam logic [5:0] ST_GO     = 6'b000000;
  localparam logic [5:0] ST_MEM    = 6'b011111;
  localparam logic [5:0] ST_BUBBLE = 6'b001111;

  typedef struct packed {
    logic [69:0] wb;
    logic [65:0] hl;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [4:0] ld, input logic [31:0] res,
                                              input logic [31:0] rd, input logic sel);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * res[1:0]));
    h = 16'(rd >> (16 * res[1]));
    if (!sel) return res;
    case (ld)
      LD_LB:   return {{24{b[7]}}, b};
      LD_LBU:  return {24'h0, b};
      LD_LH:   return {{16{h[15]}}, h};
      LD_LHU:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic model_err(input logic [4:0] ld, input logic [31:0] res);
`ifdef MEM_ADDR_ERR_CHECK_EN
    if ((ld == LD_LH || ld == LD_LHU) && res[0]) return 1'b1;
    if (ld == LD_LW && res[1:0] != 2'b00) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // drive one instruction from EX at a negedge; it sits in MEM from the next posedge
  task automatic issue(input logic [31:0] pc, input logic sel, input logic we,
                       input logic [4:0] waddr, input logic [31:0] res, input logic [4:0] ld,
                       input logic [65:0] hl, input logic [31:0] rd, input logic [5:0] stall_after);
    exp_t e;
    ex_to_mem_bus = {pc, 1'b1, 4'h0, sel, we, waddr, res};
    ex_load_bus   = ld;
    ex_hi_lo_bus  = hl;
    stall         = ST_GO;
    e.err = model_err(ld, res);
    e.wb  = {pc, we & ~e.err, waddr, model_wdata(ld, res, rd, sel)};
    e.hl  = hl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    data_sram_rdata = rd;
    stall           = stall_after;
    @(negedge clk);
  endtask

  task automatic compare_cur(input string tag);
    chk({tag, ".wb"},  mem_to_wb_bus, cur_e.wb);
    chk({tag, ".rf"},  mem_to_rf_bus, cur_e.wb[37:0]);
    chk({tag, ".hl"},  mem_hi_lo_bus, cur_e.hl);
    chk({tag, ".err"}, mem_addr_err,  cur_e.err);
  endtask

  task automatic check_stage(input string tag);
    chk({tag, ".sb"}, sb_q.size(), 1);
    if (sb_q.size() > 0) cur_e = sb_q.pop_front();
    else cur_e = '0;
    compare_cur(tag);
  endtask

  task automatic push_zero();
    exp_t e;
    e = '0;
    sb_q.push_back(e);
  endtask

  initial begin
    rst             = 1'b1;
    stall           = ST_GO;
    ex_to_mem_bus   = {$urandom, $urandom, 12'($urandom)};
    ex_load_bus     = LD_LW;
    ex_hi_lo_bus    = {2'b11, $urandom, $urandom};
    data_sram_rdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_e = '0;
    compare_cur("reset");
    rst = 1'b0;

    issue(32'hBFC0_0000, 1, 1, 5'd5, 32'h1000_0003, LD_LB, '0, 32'h80FF_1234, ST_GO);
    check_stage("t1_lb");
    issue(32'hBFC0_0004, 1, 1, 5'd6, 32'h1000_0002, LD_LHU, '0, 32'h8001_7FFF, ST_GO);
    check_stage("t2_lhu");
    issue(32'hBFC0_0008, 1, 1, 5'd7, 32'h1000_0002, LD_LH, '0, 32'h8001_7FFF, ST_GO);
    check_stage("t2_lh");
    issue(32'hBFC0_000C, 1, 1, 5'd8, 32'h1000_0000, LD_LH, '0, 32'h8001_7FFF, ST_GO);
    check_stage("lh_lo");
    issue(32'hBFC0_0010, 1, 1, 5'd9, 32'h1000_0001, LD_LBU, '0, 32'h80FF_1234, ST_GO);
    check_stage("lbu_b1");
    issue(32'hBFC0_0014, 1, 1, 5'd10, 32'h1000_0000, LD_LW, '0, 32'hA5A5_5A5A, ST_GO);
    check_stage("lw");
    issue(32'hBFC0_0018, 0, 1, 5'd11, 32'h1234_5678, LD_NONE, '0, 32'hFFFF_FFFF, ST_GO);
    check_stage("alu_res");
    issue(32'hBFC0_001C, 1, 1, 5'd12, 32'h0000_0003, LD_NONE, '0, 32'h0BAD_CAFE, ST_GO);
    check_stage("sel_noload");
    issue(32'hBFC0_0020, 0, 0, 5'd0, 32'h0000_0000, LD_NONE,
          {1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002}, 32'h0, ST_GO);
    check_stage("t5_hilo");
    issue(32'hBFC0_0024, 1, 1, 5'd13, 32'h1000_0002, LD_LW, '0, 32'h1122_3344, ST_GO);
    check_stage("t6_lw_mis");
    issue(32'hBFC0_0028, 1, 1, 5'd14, 32'h1000_0003, LD_LHU, '0, 32'h1122_3344, ST_GO);
    check_stage("t6_lhu_mis");

    // load stalled in MEM while SRAM data goes away
    issue(32'hBFC0_002C, 1, 1, 5'd15, 32'h1000_0000, LD_LW, '0, 32'hDEAD_BEEF, ST_MEM);
    check_stage("t3_fresh");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h0;
      @(negedge clk);
      compare_cur("t3_hold");
    end
    issue(32'hBFC0_0030, 1, 1, 5'd16, 32'h1000_0000, LD_LW, '0, 32'h0BAD_F00D, ST_GO);
    check_stage("after_hold");

    // reset while a held load is stalled
    issue(32'hBFC0_0034, 1, 1, 5'd17, 32'h1000_0001, LD_LB, '0, 32'hCAFE_F00D, ST_MEM);
    check_stage("rs_fresh");
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    compare_cur("rs_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cur_e = '0;
    compare_cur("rst_mid");
    rst = 1'b0;
    issue(32'hBFC0_0038, 1, 1, 5'd18, 32'h1000_0000, LD_LW, '0, 32'h1357_2468, ST_GO);
    check_stage("post_rst");

    // bubble after a captured hold, then a fresh load
    issue(32'hBFC0_003C, 1, 1, 5'd19, 32'h1000_0002, LD_LHU, {2'b11, 64'h5}, 32'hFEDC_BA98, ST_MEM);
    check_stage("bb_fresh");
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    compare_cur("bb_hold");
    stall         = ST_BUBBLE;
    ex_to_mem_bus = {$urandom, $urandom, 12'($urandom)};
    ex_load_bus   = LD_LW;
    ex_hi_lo_bus  = {2'b11, $urandom, $urandom};
    push_zero();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_stage("t4_bubble");
    issue(32'hBFC0_0040, 1, 1, 5'd20, 32'h1000_0000, LD_LW, '0, 32'h2468_ACE0, ST_GO);
    check_stage("post_bubble");

    for (int i = 0; i < 20; i++) begin
      logic [4:0] ld;
      case ($urandom_range(5, 0))
        0: ld = LD_LB;
        1: ld = LD_LBU;
        2: ld = LD_LH;
        3: ld = LD_LHU;
        4: ld = LD_LW;
        default: ld = LD_NONE;
      endcase
      issue($urandom, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, ld,
            {$urandom, $urandom, 2'($urandom)}, $urandom, ST_GO);
      check_stage("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
